// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes seen by the control unit, fetch FSM encoding
// and the address-forming helpers used by the fetch stage.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10,
    S_HALT  = 2'b11
  } fetchStateT;

  // J-type target keeps the top nibble of the sequential address.
  function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4, input logic [25:0] index);
    return {pcPlus4[31:28], index, 2'b00};
  endfunction

  function automatic logic [31:0] branchOffset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: one outstanding word request, acknowledged
// by the memory in the cycle the data is valid.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection for the retiring instruction: jump beats branch beats
// sequential. Purely combinational.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pcPlus4,
  input  logic [25:0] instr,
  input  logic        jumpTaken,
  input  logic        branchTaken,
  output logic [31:0] nextPc
);

  // Priority select of the three candidate addresses.
  always_comb begin
    nextPc = pcPlus4;
    if (jumpTaken) begin
      nextPc = jumpTarget(pcPlus4, instr);
    end else if (branchTaken) begin
      nextPc = pcPlus4 + branchOffset(instr[15:0]);
    end else begin
      nextPc = pcPlus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, reads one instruction word at a time over the
// imem handshake and steps to the next PC when the instruction retires.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  instr_fetch_unit_if.master bus,
  output logic [31:0]        instr,
  output logic               instr_valid,
  input  logic               instr_done,
  input  logic               jump_taken,
  input  logic               branch_taken,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        retired_cnt,
  output logic               fetch_err
);

  localparam int unsigned      CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  fetchStateT       stateR;
  fetchStateT       stateNextS;
  logic             reqR;
  logic             reqNextS;
  logic             validR;
  logic             validNextS;
  logic [CNT_W-1:0] countR;
  logic [31:0]      instrR;
  logic [31:0]      pcR;
  logic [31:0]      pcPlus4R;
  logic [31:0]      retiredCntR;
  logic             fetchErrR;
  logic [31:0]      nextPcS;
  logic             ackS;
  logic             retireS;
  logic             timeoutS;

  // Handshake qualifiers: ack only counts while a request is out, done only while issuing.
  assign ackS     = (stateR == S_FETCH) && reqR && bus.imem_ack;
  assign retireS  = (stateR == S_ISSUE) && validR && instr_done;
  assign timeoutS = (stateR == S_FETCH) && !ackS && (countR == CNT_LAST);

  next_pc_calc u_nextPcCalc (
    .pcPlus4    (pcPlus4R),
    .instr      (instrR[25:0]),
    .jumpTaken  (jump_taken),
    .branchTaken(branch_taken),
    .nextPc     (nextPcS)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateR <= S_IDLE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      S_IDLE:  stateNextS = S_FETCH;
      S_FETCH: begin
        if (ackS) begin
          stateNextS = S_ISSUE;
        end else if (timeoutS) begin
          stateNextS = S_HALT;
        end else begin
          stateNextS = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (retireS) begin
          stateNextS = S_FETCH;
        end else begin
          stateNextS = S_ISSUE;
        end
      end
      S_HALT:  stateNextS = S_HALT;
      default: stateNextS = S_IDLE;
    endcase
  end

  // Output decode from the next state, so req/valid leave this block as flops.
  always_comb begin
    reqNextS   = 1'b0;
    validNextS = 1'b0;
    case (stateNextS)
      S_FETCH: reqNextS   = 1'b1;
      S_ISSUE: validNextS = 1'b1;
      S_IDLE:  reqNextS   = 1'b0;
      S_HALT:  validNextS = 1'b0;
      default: reqNextS   = 1'b0;
    endcase
  end

  // Handshake output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reqR   <= 1'b0;
      validR <= 1'b0;
    end else begin
      reqR   <= reqNextS;
      validR <= validNextS;
    end
  end

  // Instruction capture and PC update on retirement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrR   <= 32'h0000_0000;
      pcR      <= RESET_PC;
      pcPlus4R <= RESET_PC + PC_STEP;
    end else begin
      if (ackS) begin
        instrR <= bus.imem_rdata;
      end
      if (retireS) begin
        pcR      <= nextPcS;
        pcPlus4R <= nextPcS + PC_STEP;
      end
    end
  end

  // Retire counter, ack timeout counter and the sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retiredCntR <= 32'h0000_0000;
      countR      <= CNT_ZERO;
      fetchErrR   <= 1'b0;
    end else begin
      if (retireS) begin
        retiredCntR <= retiredCntR + 32'd1;
        countR      <= CNT_ZERO;
      end else if ((stateR == S_FETCH) && !ackS) begin
        countR <= countR + CNT_ONE;
      end
      if (timeoutS) begin
        fetchErrR <= 1'b1;
      end
    end
  end

  assign bus.imem_req  = reqR;
  assign bus.imem_addr = pcR;
  assign instr         = instrR;
  assign instr_valid   = validR;
  assign pc            = pcR;
  assign pc_plus4      = pcPlus4R;
  assign retired_cnt   = retiredCntR;
  assign fetch_err     = fetchErrR;

endmodule
